// File: rtl/program_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_arbiter
// Purpose  : Shares NUM_CHANNELS program-memory read channels between
//            NUM_CONSUMERS instruction fetchers. Idle channels grant eligible
//            requests round-robin, forward the address to memory, and hand
//            the returned instruction word back to the owning fetcher.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            consumer_read_valid/address - per-fetcher request (held until ready)
//            consumer_read_ready/data    - per-fetcher response, registered
//            mem_read_valid/address      - per-channel memory request
//            mem_read_ready/data         - per-channel memory response
//            All packed buses use slice i at [(i+1)*W-1 : i*W].
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

  localparam int c_PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAITING  = 2'd1,
    S_RELAYING = 2'd2
  } chan_state_t;

  chan_state_t              r_state      [NUM_CHANNELS];
  chan_state_t              w_state_next [NUM_CHANNELS];
  logic [c_PTR_W-1:0]       r_owner      [NUM_CHANNELS];
  logic [c_PTR_W-1:0]       r_rr_ptr;

  logic [NUM_CONSUMERS-1:0]           r_cons_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_cons_data;
  logic [NUM_CHANNELS-1:0]            r_mem_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  r_mem_addr;

  logic [NUM_CONSUMERS-1:0] w_owned;
  logic [NUM_CONSUMERS-1:0] w_eligible;
  logic [NUM_CONSUMERS-1:0] w_taken;
  logic [NUM_CHANNELS-1:0]  w_grant;
  logic [NUM_CHANNELS-1:0]  w_resp;
  logic [NUM_CHANNELS-1:0]  w_release;
  logic [NUM_CHANNELS-1:0]  w_owner_valid;
  logic [c_PTR_W-1:0]       w_grant_idx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     w_grant_addr [NUM_CHANNELS];
  logic [c_PTR_W-1:0]       w_rr_next;

  // --------------------------------------------------------------------------
  // Channel state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= S_IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= w_state_next[c];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Eligibility, round-robin grant and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    int                 j;
    logic [c_PTR_W-1:0] idx;

    j             = 0;
    idx           = '0;
    w_owned       = '0;
    w_taken       = '0;
    w_grant       = '0;
    w_resp        = '0;
    w_release     = '0;
    w_owner_valid = '0;
    w_rr_next     = r_rr_ptr;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_grant_idx[c]  = '0;
      w_grant_addr[c] = '0;
      w_state_next[c] = r_state[c];
    end

    // A consumer held by any busy channel (WAITING or RELAYING) cannot be
    // granted again until that channel releases it.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (r_owner[c] == c_PTR_W'(i)) begin
          if (r_state[c] != S_IDLE) begin
            w_owned[i] = 1'b1;
          end
          w_owner_valid[c] = consumer_read_valid[i];
        end
      end
    end
    w_eligible = consumer_read_valid & ~w_owned;

    // Idle channels are served in ascending index; each searches from rr_ptr
    // with wrap, skipping consumers already taken by a lower channel.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (r_state[c] == S_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          j = int'(r_rr_ptr) + k;
          if (j >= NUM_CONSUMERS) begin
            j = j - NUM_CONSUMERS;
          end
          idx = c_PTR_W'(j);
          if (!w_grant[c] && w_eligible[idx] && !w_taken[idx]) begin
            w_grant[c]     = 1'b1;
            w_grant_idx[c] = idx;
            w_taken[idx]   = 1'b1;
          end
        end
        // The last granting channel in scan order sets the pointer.
        if (w_grant[c]) begin
          if (w_grant_idx[c] == c_PTR_W'(NUM_CONSUMERS - 1)) begin
            w_rr_next = '0;
          end else begin
            w_rr_next = w_grant_idx[c] + 1'b1;
          end
        end
      end
    end

    // Address capture mux for each granting channel.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (w_grant_idx[c] == c_PTR_W'(i)) begin
          w_grant_addr[c] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        end
      end
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (r_state[c])
        S_IDLE: begin
          if (w_grant[c]) begin
            w_state_next[c] = S_WAITING;
          end
        end
        S_WAITING: begin
          if (mem_read_ready[c]) begin
            w_resp[c]       = 1'b1;
            w_state_next[c] = S_RELAYING;
          end
        end
        S_RELAYING: begin
          if (!w_owner_valid[c]) begin
            w_release[c]    = 1'b1;
            w_state_next[c] = S_IDLE;
          end
        end
        default: begin
          w_state_next[c] = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers: owners, pointer, memory request and consumer response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_cons_ready <= '0;
      r_cons_data  <= '0;
      r_mem_valid  <= '0;
      r_mem_addr   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_owner[c] <= '0;
      end
    end else begin
      r_rr_ptr <= w_rr_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_grant[c]) begin
          r_owner[c]                           <= w_grant_idx[c];
          r_mem_valid[c]                       <= 1'b1;
          r_mem_addr[c*ADDR_BITS +: ADDR_BITS] <= w_grant_addr[c];
        end
        if (w_resp[c]) begin
          r_mem_valid[c] <= 1'b0;
        end
        // Owners are unique across busy channels, so these per-consumer
        // writes never collide between channels.
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          if (r_owner[c] == c_PTR_W'(i)) begin
            if (w_resp[c]) begin
              r_cons_ready[i]                       <= 1'b1;
              r_cons_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
            end
            if (w_release[c]) begin
              r_cons_ready[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign consumer_read_ready = r_cons_ready;
  assign consumer_read_data  = r_cons_data;
  assign mem_read_valid      = r_mem_valid;
  assign mem_read_address    = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_arbiter
// Purpose  : Directed self-checking bench. u_dut1 uses one channel, u_dut2 two.
//            Inputs change 1ns after a rising edge; outputs are sampled there.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_arbiter;

  logic clk;
  logic reset;

  logic [3:0]  c1_valid;
  logic [31:0] c1_addr;
  logic [3:0]  c1_ready;
  logic [63:0] c1_data;
  logic [0:0]  m1_valid;
  logic [7:0]  m1_addr;
  logic [0:0]  m1_ready;
  logic [15:0] m1_data;

  logic [3:0]  c2_valid;
  logic [31:0] c2_addr;
  logic [3:0]  c2_ready;
  logic [63:0] c2_data;
  logic [1:0]  m2_valid;
  logic [15:0] m2_addr;
  logic [1:0]  m2_ready;
  logic [31:0] m2_data;

  int n_checks;
  int n_errors;

  program_memory_arbiter #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(16)
  ) u_dut1 (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (c1_valid),
    .consumer_read_address(c1_addr),
    .consumer_read_ready  (c1_ready),
    .consumer_read_data   (c1_data),
    .mem_read_valid       (m1_valid),
    .mem_read_address     (m1_addr),
    .mem_read_ready       (m1_ready),
    .mem_read_data        (m1_data)
  );

  program_memory_arbiter #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16)
  ) u_dut2 (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (c2_valid),
    .consumer_read_address(c2_addr),
    .consumer_read_ready  (c2_ready),
    .consumer_read_data   (c2_data),
    .mem_read_valid       (m2_valid),
    .mem_read_address     (m2_addr),
    .mem_read_ready       (m2_ready),
    .mem_read_data        (m2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem1_respond(input logic [15:0] d);
    m1_ready = 1'b1;
    m1_data  = d;
    tick();
    m1_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] who;
    n_checks = 0;
    n_errors = 0;
    c1_valid = '0; c1_addr = '0; m1_ready = '0; m1_data = '0;
    c2_valid = '0; c2_addr = '0; m2_ready = '0; m2_data = '0;
    do_reset();

    // Reset state
    check("rst_c_ready", {60'd0, c1_ready}, 64'd0);
    check("rst_c_data",  c1_data, 64'd0);
    check("rst_m_valid", {63'd0, m1_valid}, 64'd0);
    check("rst_m_addr",  {56'd0, m1_addr}, 64'd0);

    // 1. Single read: fetcher 2, addr 0x1A, memory answers 3 cycles later
    c1_addr[2*8 +: 8] = 8'h1A;
    c1_valid          = 4'b0100;
    tick();
    check("t1_m_valid", {63'd0, m1_valid}, 64'd1);
    check("t1_m_addr",  {56'd0, m1_addr}, 64'h1A);
    tick();
    tick();
    check("t1_m_addr_hold", {56'd0, m1_addr}, 64'h1A);
    mem1_respond(16'hBEEF);
    check("t1_ready_1st", {60'd0, c1_ready}, 64'b0100);
    check("t1_data",      {48'd0, c1_data[2*16 +: 16]}, 64'hBEEF);
    check("t1_m_valid_lo", {63'd0, m1_valid}, 64'd0);
    tick();
    check("t1_ready_2nd", {60'd0, c1_ready}, 64'b0100);
    c1_valid = 4'b0000;
    tick();
    check("t1_ready_lo",  {60'd0, c1_ready}, 64'd0);
    check("t1_data_keep", {48'd0, c1_data[2*16 +: 16]}, 64'hBEEF);

    // 5. Stray ready on idle channel, then slow memory
    mem1_respond(16'h5A5A);
    check("t5_stray_ready", {60'd0, c1_ready}, 64'd0);
    check("t5_stray_data",  {48'd0, c1_data[2*16 +: 16]}, 64'hBEEF);
    c1_addr[1*8 +: 8] = 8'h55;
    c1_valid          = 4'b0010;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t5_slow_valid", {63'd0, m1_valid}, 64'd1);
      check("t5_slow_addr",  {56'd0, m1_addr}, 64'h55);
      tick();
    end
    mem1_respond(16'h1234);
    check("t5_ready", {60'd0, c1_ready}, 64'b0010);
    check("t5_data",  {48'd0, c1_data[1*16 +: 16]}, 64'h1234);
    c1_valid = 4'b0000;
    tick();

    // 2. Contention on one channel: fetchers 0, 1, 3
    do_reset();
    c1_addr  = {8'h13, 8'h00, 8'h11, 8'h10};
    c1_valid = 4'b1011;
    tick();
    check("t2_addr_a", {56'd0, m1_addr}, 64'h10);
    mem1_respond(16'hA000);
    check("t2_ready_a", {60'd0, c1_ready}, 64'b0001);
    check("t2_data_a",  {48'd0, c1_data[0 +: 16]}, 64'hA000);
    c1_valid[0] = 1'b0;
    tick();
    tick();
    check("t2_addr_b", {56'd0, m1_addr}, 64'h11);
    mem1_respond(16'hA001);
    check("t2_ready_b", {60'd0, c1_ready}, 64'b0010);
    check("t2_data_b",  {48'd0, c1_data[1*16 +: 16]}, 64'hA001);
    check("t2_data_a_keep", {48'd0, c1_data[0 +: 16]}, 64'hA000);
    c1_valid[1] = 1'b0;
    tick();
    tick();
    check("t2_addr_c", {56'd0, m1_addr}, 64'h13);
    mem1_respond(16'hA003);
    check("t2_ready_c", {60'd0, c1_ready}, 64'b1000);
    check("t2_data_c",  {48'd0, c1_data[3*16 +: 16]}, 64'hA003);
    c1_valid[3] = 1'b0;
    tick();
    // Pointer must be back at 0: fetcher 0 wins over fetcher 3
    c1_addr  = {8'h33, 8'h00, 8'h00, 8'h30};
    c1_valid = 4'b1001;
    tick();
    check("t2_rr_wrap", {56'd0, m1_addr}, 64'h30);

    // 6. Reset in WAITING with the response arriving in the same cycle
    reset    = 1'b1;
    m1_ready = 1'b1;
    m1_data  = 16'hDEAD;
    c1_valid = 4'b0000;
    tick();
    reset    = 1'b0;
    m1_ready = 1'b0;
    check("t6_c_ready", {60'd0, c1_ready}, 64'd0);
    check("t6_c_data",  c1_data, 64'd0);
    check("t6_m_valid", {63'd0, m1_valid}, 64'd0);
    check("t6_m_addr",  {56'd0, m1_addr}, 64'd0);
    mem1_respond(16'hDEAD);
    check("t6_late_ready", {60'd0, c1_ready}, 64'd0);
    c1_valid = 4'b1001;
    tick();
    check("t6_rr0_addr", {56'd0, m1_addr}, 64'h30);
    mem1_respond(16'h7777);
    check("t6_ready", {60'd0, c1_ready}, 64'b0001);
    check("t6_data",  {48'd0, c1_data[0 +: 16]}, 64'h7777);
    c1_valid = 4'b0000;
    tick();

    // 3. Fairness: fetcher 0 re-requests at once, fetcher 1 holds
    do_reset();
    c1_addr  = {8'h00, 8'h00, 8'h41, 8'h40};
    c1_valid = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      who = (g % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
      check("t3_grant_addr", {56'd0, m1_addr}, (g % 2 == 0) ? 64'h40 : 64'h41);
      mem1_respond(16'hC000 + 16'(g));
      check("t3_ready", {60'd0, c1_ready}, {60'd0, who});
      c1_valid = c1_valid & ~who;
      tick();
      c1_valid = c1_valid | who;
    end
    c1_valid = 4'b0000;
    tick();

    // 4. Two channels: fetchers 0, 1, 2 together
    c2_addr  = {8'h00, 8'h22, 8'h21, 8'h20};
    c2_valid = 4'b0111;
    tick();
    check("t4_m_valid_both", {62'd0, m2_valid}, 64'b11);
    check("t4_m_addr_both",  {48'd0, m2_addr}, 64'h2120);
    m2_ready = 2'b10;
    m2_data  = {16'h2221, 16'h0000};
    tick();
    m2_ready = 2'b00;
    check("t4_ready_f1", {60'd0, c2_ready}, 64'b0010);
    check("t4_data_f1",  {48'd0, c2_data[1*16 +: 16]}, 64'h2221);
    check("t4_m_valid_ch0", {62'd0, m2_valid}, 64'b01);
    c2_valid[1] = 1'b0;
    tick();
    check("t4_ready_f1_lo", {60'd0, c2_ready}, 64'd0);
    tick();
    check("t4_m_valid_f2", {62'd0, m2_valid}, 64'b11);
    check("t4_m_addr_f2",  {48'd0, m2_addr}, 64'h2220);
    m2_ready = 2'b11;
    m2_data  = {16'h2222, 16'h2220};
    tick();
    m2_ready = 2'b00;
    check("t4_ready_f0f2", {60'd0, c2_ready}, 64'b0101);
    check("t4_data_f0",    {48'd0, c2_data[0 +: 16]}, 64'h2220);
    check("t4_data_f2",    {48'd0, c2_data[2*16 +: 16]}, 64'h2222);
    c2_valid = 4'b0000;
    tick();
    tick();
    check("t4_idle_ready", {60'd0, c2_ready}, 64'd0);
    check("t4_idle_valid", {62'd0, m2_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
